// File: rtl/dram_tester_pkg.sv
// Shared encodings for the DRAM write/read-verify engine: FSM states, UI
// commands, pattern modes and the LFSR step used by both pattern generators.
package dram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CAL = 3'd1,
    ST_WRITE    = 3'd2,
    ST_READ     = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_INDEX = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois LFSR: feed the dropped bit back through the taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/m_dram_tester_pattern_gen.sv
// 32-bit test-pattern source replicated across the data bus; one instance
// follows the write stream, another follows the read-compare stream.
module m_pattern_gen
  import dram_tester_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int IDX_W  = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  input  logic              step,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data
);

  mode_e       mode_p0;
  logic [31:0] seed_p0;
  logic [31:0] lfsr_p0;
  logic [31:0] word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0 <= MODE_CONST;
      seed_p0 <= '0;
      lfsr_p0 <= '0;
    end else if (load) begin
      mode_p0 <= (mode == MODE_RSVD) ? MODE_CONST : mode_e'(mode);
      seed_p0 <= seed;
      // An all-zero LFSR would lock up, so a zero seed starts from 1.
      lfsr_p0 <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      lfsr_p0 <= lfsr_next(lfsr_p0);
    end
  end

  always_comb begin
    word = seed_p0;
    case (mode_p0)
      MODE_INDEX: word = 32'(idx) + seed_p0;
      MODE_LFSR:  word = lfsr_p0;
      default:    word = seed_p0;
    endcase
  end

  assign data = {(DATA_W/32){word}};

endmodule

// File: rtl/m_dram_tester.sv
// DRAM write/read-verify engine on the MIG 7-series UI: fills an index range
// with a pattern, reads it back with bounded outstanding reads and compares.
module m_dram_tester
  import dram_tester_pkg::*;
#(
  parameter int ADDR_W          = 28,
  parameter int DATA_W          = 128,
  parameter int MASK_W          = 16,
  parameter int ADDR_STEP       = 8,
  parameter int IDX_W           = 25,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_start,
  input  logic [1:0]        w_mode,
  input  logic [31:0]       w_seed,
  input  logic [IDX_W-1:0]  w_last_idx,
  input  logic              w_calib_done,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [MASK_W-1:0] app_wdf_mask,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic              r_busy,
  output logic              r_done,
  output logic              r_pass,
  output logic [31:0]       r_err_cnt,
  output logic [IDX_W-1:0]  r_first_err_idx,
  output logic [31:0]       r_sum,
  output logic [2:0]        r_state
);

  state_e            state_p0, state_d;
  logic [IDX_W:0]    idx_p0;
  logic [IDX_W-1:0]  cmp_idx_p0;
  logic [IDX_W-1:0]  last_idx_p0;
  logic [3:0]        outst_p0;
  logic              cmd_acc_p0, dat_acc_p0;
  logic [31:0]       err_cnt_p0, sum_p0;
  logic [IDX_W-1:0]  first_err_p0;
  logic              done_p0, pass_p0;

  logic [DATA_W-1:0] wr_data, cmp_data;
  logic [ADDR_W-1:0] idx_addr;
  logic start_ok, cmd_fire, dat_fire, wr_word_done, wr_last;
  logic rd_fire, rd_vld, rd_mismatch, rd_last;

  assign start_ok     = w_start && (state_p0 == ST_IDLE || state_p0 == ST_DONE);
  assign cmd_fire     = app_en && app_rdy;
  assign dat_fire     = app_wdf_wren && app_wdf_rdy;
  // Command and data of a word may complete in either order or together.
  assign wr_word_done = (state_p0 == ST_WRITE) && (cmd_acc_p0 || cmd_fire)
                        && (dat_acc_p0 || dat_fire);
  assign wr_last      = wr_word_done && (idx_p0[IDX_W-1:0] == last_idx_p0);
  assign rd_fire      = (state_p0 == ST_READ) && cmd_fire;
  assign rd_vld       = (state_p0 == ST_READ) && app_rd_data_valid;
  assign rd_mismatch  = (app_rd_data != cmp_data);
  assign rd_last      = rd_vld && (cmp_idx_p0 == last_idx_p0);
  assign idx_addr     = ADDR_W'(idx_p0) * ADDR_W'(ADDR_STEP);

  m_pattern_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_wr_gen (
    .clk(w_clk), .rst_n(w_rst_n), .load(start_ok), .mode(w_mode), .seed(w_seed),
    .step((state_p0 == ST_WRITE) && dat_fire), .idx(idx_p0[IDX_W-1:0]),
    .data(wr_data)
  );

  m_pattern_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp_gen (
    .clk(w_clk), .rst_n(w_rst_n), .load(start_ok), .mode(w_mode), .seed(w_seed),
    .step(rd_vld), .idx(cmp_idx_p0), .data(cmp_data)
  );

  // State register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state_p0 <= ST_IDLE;
    else          state_p0 <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_p0;
    case (state_p0)
      ST_IDLE, ST_DONE: if (start_ok)     state_d = ST_WAIT_CAL;
      ST_WAIT_CAL:      if (w_calib_done) state_d = ST_WRITE;
      ST_WRITE:         if (wr_last)      state_d = ST_READ;
      ST_READ:          if (rd_last)      state_d = ST_DONE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // UI strobes and status outputs
  always_comb begin
    app_en       = 1'b0;
    app_cmd      = CMD_WRITE;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_data = '0;
    case (state_p0)
      ST_WRITE: begin
        app_en       = !cmd_acc_p0;
        app_addr     = idx_addr;
        app_wdf_wren = !dat_acc_p0;
        app_wdf_data = wr_data;
      end
      ST_READ: begin
        app_en   = (idx_p0 <= {1'b0, last_idx_p0}) &&
                   (outst_p0 < 4'(MAX_OUTSTANDING));
        app_cmd  = CMD_READ;
        app_addr = idx_addr;
      end
      default: ;
    endcase
  end

  assign app_wdf_end     = app_wdf_wren;
  assign app_wdf_mask    = '0;
  assign r_busy          = (state_p0 == ST_WAIT_CAL) || (state_p0 == ST_WRITE) ||
                           (state_p0 == ST_READ);
  assign r_state         = state_p0;
  assign r_done          = done_p0;
  assign r_pass          = pass_p0;
  assign r_err_cnt       = err_cnt_p0;
  assign r_first_err_idx = first_err_p0;
  assign r_sum           = sum_p0;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      idx_p0       <= '0;
      cmp_idx_p0   <= '0;
      last_idx_p0  <= '0;
      outst_p0     <= '0;
      cmd_acc_p0   <= 1'b0;
      dat_acc_p0   <= 1'b0;
      err_cnt_p0   <= '0;
      first_err_p0 <= '0;
      sum_p0       <= '0;
      done_p0      <= 1'b0;
      pass_p0      <= 1'b0;
    end else if (start_ok) begin
      idx_p0       <= '0;
      cmp_idx_p0   <= '0;
      last_idx_p0  <= w_last_idx;
      outst_p0     <= '0;
      cmd_acc_p0   <= 1'b0;
      dat_acc_p0   <= 1'b0;
      err_cnt_p0   <= '0;
      first_err_p0 <= '0;
      sum_p0       <= '0;
      done_p0      <= 1'b0;
      pass_p0      <= 1'b0;
    end else if (state_p0 == ST_WRITE) begin
      if (wr_word_done) begin
        idx_p0     <= wr_last ? '0 : idx_p0 + 1'b1;
        cmd_acc_p0 <= 1'b0;
        dat_acc_p0 <= 1'b0;
      end else begin
        if (cmd_fire) cmd_acc_p0 <= 1'b1;
        if (dat_fire) dat_acc_p0 <= 1'b1;
      end
    end else if (state_p0 == ST_READ) begin
      if (rd_fire) idx_p0 <= idx_p0 + 1'b1;
      if (rd_fire && !rd_vld)      outst_p0 <= outst_p0 + 1'b1;
      else if (!rd_fire && rd_vld) outst_p0 <= outst_p0 - 1'b1;
      if (rd_vld) begin
        if (rd_mismatch && err_cnt_p0 != 32'hFFFF_FFFF) err_cnt_p0 <= err_cnt_p0 + 1'b1;
        if (rd_mismatch && err_cnt_p0 == 32'h0)         first_err_p0 <= cmp_idx_p0;
        sum_p0     <= sum_p0 + app_rd_data[31:0];
        cmp_idx_p0 <= cmp_idx_p0 + 1'b1;
      end
      if (rd_last) begin
        done_p0 <= 1'b1;
        pass_p0 <= (err_cnt_p0 == 32'h0) && !rd_mismatch;
      end
    end
  end

endmodule

// File: tb/tb_m_dram_tester.sv
// Directed bench for m_dram_tester with a behavioural MIG UI memory model and
// queues of expected write/read traffic filled when each run is launched.
module tb_m_dram_tester;

  localparam int ADDR_W = 28, DATA_W = 128, MASK_W = 16, ADDR_STEP = 8, IDX_W = 25;
  localparam int MAXO = 2;

  logic              w_clk, w_rst_n, w_start, w_calib_done;
  logic [1:0]        w_mode;
  logic [31:0]       w_seed;
  logic [IDX_W-1:0]  w_last_idx;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy;
  logic [DATA_W-1:0] app_wdf_data, app_rd_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_rd_data_valid;
  logic              r_busy, r_done, r_pass;
  logic [31:0]       r_err_cnt, r_sum;
  logic [IDX_W-1:0]  r_first_err_idx;
  logic [2:0]        r_state;

  m_dram_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_STEP(ADDR_STEP),
    .IDX_W(IDX_W), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start), .w_mode(w_mode),
    .w_seed(w_seed), .w_last_idx(w_last_idx), .w_calib_done(w_calib_done),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .r_busy(r_busy), .r_done(r_done),
    .r_pass(r_pass), .r_err_cnt(r_err_cnt), .r_first_err_idx(r_first_err_idx),
    .r_sum(r_sum), .r_state(r_state)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected traffic and results for the run in progress
  logic [ADDR_W-1:0] exp_waddr[$], exp_raddr[$];
  logic [DATA_W-1:0] exp_wdata[$];
  logic [31:0]       exp_sum, exp_err;
  int                exp_first;

  // Memory model configuration and state
  typedef struct { int idx; int due; } rd_t;
  rd_t               rd_q[$];
  int                wcmd_q[$];
  logic [DATA_W-1:0] wdat_q[$];
  logic [DATA_W-1:0] mem [int];
  int cyc = 0, outst = 0, peak = 0, lat = 20, corrupt_a = -1, corrupt_b = -1;
  bit rnd_rdy = 0;

  function automatic logic [31:0] lstep(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  initial begin
    rd_t e;
    logic [DATA_W-1:0] d;
    app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0; app_rd_data = '0;
    forever begin
      @(negedge w_clk);
      cyc++;
      if (!w_rst_n) begin
        rd_q.delete(); wcmd_q.delete(); wdat_q.delete();
        outst = 0; app_rdy = 0; app_wdf_rdy = 0; app_rd_data_valid = 0;
        continue;
      end
      app_rdy     = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      app_wdf_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      app_rd_data_valid = 0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        e = rd_q.pop_front();
        d = mem[e.idx];
        if (e.idx == corrupt_a || e.idx == corrupt_b) d[64] = ~d[64];
        app_rd_data = d;
        app_rd_data_valid = 1;
        outst--;
      end
      if (app_en && app_rdy) begin
        chk("en_state", (r_state == 3'd2 || r_state == 3'd3), 1);
        if (app_cmd == 3'b000) begin
          if (exp_waddr.size() == 0) chk("wr_cmd_extra", 1, 0);
          else chk("wr_addr", app_addr, exp_waddr.pop_front());
          wcmd_q.push_back(int'(app_addr) / ADDR_STEP);
        end else begin
          chk("rd_cmd", app_cmd, 3'b001);
          if (exp_raddr.size() == 0) chk("rd_cmd_extra", 1, 0);
          else chk("rd_addr", app_addr, exp_raddr.pop_front());
          rd_q.push_back('{idx: int'(app_addr) / ADDR_STEP, due: cyc + lat});
          outst++;
          if (outst > peak) peak = outst;
          chk("outstanding_le_max", outst <= MAXO, 1);
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        chk("wdf_end_mask", {app_wdf_end, app_wdf_mask}, {1'b1, 16'h0});
        if (exp_wdata.size() == 0) chk("wr_data_extra", 1, 0);
        else chk("wr_data", app_wdf_data, exp_wdata.pop_front());
        wdat_q.push_back(app_wdf_data);
      end
      while (wcmd_q.size() > 0 && wdat_q.size() > 0)
        mem[wcmd_q.pop_front()] = wdat_q.pop_front();
    end
  end

  task automatic clear_exp();
    exp_waddr.delete(); exp_raddr.delete(); exp_wdata.delete();
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [31:0] seed, input int last,
                           input int latency, input bit rnd, input int ca, input int cb);
    logic [31:0] x, p;
    clear_exp();
    lat = latency; rnd_rdy = rnd; corrupt_a = ca; corrupt_b = cb; peak = 0;
    x = (seed == 0) ? 32'h1 : seed;
    exp_sum = 0; exp_err = 0; exp_first = 0;
    for (int i = 0; i <= last; i++) begin
      case (mode)
        2'd1:    p = 32'(i) + seed;
        2'd2:    p = x;
        default: p = seed;
      endcase
      x = lstep(x);
      exp_waddr.push_back(ADDR_W'(i * ADDR_STEP));
      exp_raddr.push_back(ADDR_W'(i * ADDR_STEP));
      exp_wdata.push_back({4{p}});
      exp_sum += p;
      if (i == ca || i == cb) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    @(negedge w_clk);
    w_mode = mode; w_seed = seed; w_last_idx = IDX_W'(last); w_start = 1;
    @(negedge w_clk);
    w_start = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (r_state !== s && n < budget) begin @(negedge w_clk); #1; n++; end
    chk("wait_state", r_state, s);
  endtask

  task automatic finish_run();
    int n = 0;
    while (r_done !== 1'b1 && n < 5000) begin @(negedge w_clk); #1; n++; end
    chk("done", r_done, 1);
    chk("pass", r_pass, exp_err == 0);
    chk("err_cnt", r_err_cnt, exp_err);
    chk("first_err_idx", r_first_err_idx, IDX_W'(exp_first));
    chk("sum", r_sum, exp_sum);
    chk("state_done", r_state, 3'd4);
    chk("busy_off", r_busy, 0);
    chk("all_traffic_seen", {exp_waddr.size(), exp_wdata.size(), exp_raddr.size()}, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {app_addr, app_cmd, app_en, app_wdf_wren, app_wdf_end, app_wdf_mask,
              r_busy, r_done, r_pass, r_state}, 0);
    chk({tag, "_data"}, app_wdf_data, 0);
    chk({tag, "_stat"}, {r_err_cnt, r_first_err_idx, r_sum}, 0);
  endtask

  initial begin
    bit en_seen;
    w_rst_n = 0; w_start = 0; w_mode = 0; w_seed = 0; w_last_idx = 0; w_calib_done = 1;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(negedge w_clk);
    w_rst_n = 1;

    // Constant pattern, ideal memory
    start_run(2'd0, 32'h1, 15, 20, 0, -1, -1);
    finish_run();

    // LFSR from zero seed under random back-pressure
    start_run(2'd2, 32'h0, 20, 5, 1, -1, -1);
    finish_run();

    // Index+seed with two corrupted words on readback
    start_run(2'd1, 32'h100, 15, 20, 0, 5, 9);
    finish_run();

    // Long latency: read pipeline fills to exactly MAXO
    start_run(2'd1, 32'hDEAD_0000, 9, 30, 0, -1, -1);
    finish_run();
    chk("peak_outstanding", peak, MAXO);

    // Single word
    start_run(2'd1, 32'h7, 0, 3, 0, -1, -1);
    finish_run();

    // Calibration held low, then a stray start during WRITE
    w_calib_done = 0;
    start_run(2'd2, 32'h1234_5678, 31, 8, 1, -1, -1);
    en_seen = 0;
    for (int i = 0; i < 100; i++) begin @(negedge w_clk); #1; en_seen |= app_en; end
    chk("no_en_before_cal", en_seen, 0);
    chk("state_wait_cal", r_state, 3'd1);
    w_calib_done = 1;
    wait_state(3'd2, 20);
    @(negedge w_clk);
    w_start = 1; w_last_idx = 3; w_mode = 0;
    @(negedge w_clk);
    w_start = 0;
    chk("busy_after_stray_start", r_busy, 1);
    finish_run();

    // Reset in the middle of READ, then a clean restart in mode 3
    start_run(2'd1, 32'h3, 15, 20, 0, -1, -1);
    wait_state(3'd3, 200);
    repeat (4) @(negedge w_clk);
    #2;
    w_rst_n = 0;
    #1;
    chk_outputs_zero("mid_read_reset");
    clear_exp();
    repeat (2) @(negedge w_clk);
    w_rst_n = 1;
    start_run(2'd3, 32'hA5A5_A5A5, 7, 6, 0, -1, -1);
    finish_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_dram_tester.md
Name: m_dram_tester

Overview:
- Parametrised DRAM write/read-verify engine driving the MIG 7-series application (UI) interface in the w_ui_clk domain.
- Fills a programmable index range with a selectable pattern, reads it back with up to MAX_OUTSTANDING reads in flight, and compares every returned word.
- Reports pass/fail, error count, first failing index and a running checksum; intended for VIO/LED observation on Arty A7 boards.

Parameters:
- ADDR_W, 28, app_addr width.
- DATA_W, 128, app data width; must be a multiple of 32.
- MASK_W, 16, app_wdf_mask width (DATA_W/8).
- ADDR_STEP, 8, app_addr increment per word (BL8 x16 device).
- IDX_W, 25, word index width.
- MAX_OUTSTANDING, 4, maximum read commands awaiting data; range 1..15.

Ports:
- w_clk  in  1  UI clock (connect to the controller's ui_clk).
- w_rst_n  in  1  asynchronous active-low reset.
- w_start  in  1  single-cycle start pulse; ignored unless in IDLE or DONE.
- w_mode  in  2  pattern: 0 constant, 1 index+seed, 2 LFSR, 3 treated as 0.
- w_seed  in  32  pattern seed.
- w_last_idx  in  IDX_W  last word index, inclusive; sampled on start.
- w_calib_done  in  1  init_calib_complete.
- app_addr  out  ADDR_W;  app_cmd  out  3 (000 write, 001 read);  app_en  out  1.
- app_wdf_data  out  DATA_W;  app_wdf_wren  out  1;  app_wdf_end  out  1 (equals app_wdf_wren);  app_wdf_mask  out  MASK_W (always 0).
- app_rdy  in  1;  app_wdf_rdy  in  1;  app_rd_data  in  DATA_W;  app_rd_data_valid  in  1.
- r_busy  out  1;  r_done  out  1;  r_pass  out  1.
- r_err_cnt  out  32  saturating mismatch count.
- r_first_err_idx  out  IDX_W  index of the first mismatch.
- r_sum  out  32  modulo-2^32 sum of app_rd_data[31:0] over all read words.
- r_state  out  3  state encoding, for LEDs.

Behaviour:
- Reset: every output 0; state IDLE; all counters 0.
- States: IDLE=0, WAIT_CAL=1, WRITE=2, READ=3, DONE=4.
- IDLE/DONE + w_start:
  - Latch mode, seed and last_idx.
  - Clear err_cnt, sum, first_err_idx, pass and done.
  - Go to WAIT_CAL; r_busy=1.
- WAIT_CAL: go to WRITE on the first cycle w_calib_done=1.
- Pattern word for index i is a 32-bit value P(i) replicated DATA_W/32 times:
  - mode 0: P = seed.
  - mode 1: P = zero-extended i + seed.
  - mode 2: 32-bit Galois LFSR, taps 0x80200003, shifted right once per word. P(0) = seed, or 1 if seed==0.
  - Write side and read-compare side each keep an independent generator, stepped on write-data acceptance and read-data arrival respectively.
- WRITE:
  - Present app_en=1, app_cmd=000, app_addr = i*ADDR_STEP, app_wdf_wren=1, app_wdf_data = pattern(i).
  - Command is accepted when app_en&app_rdy; data is accepted when app_wdf_wren&app_wdf_rdy. They may be accepted in different cycles.
  - Each strobe drops the cycle after its own acceptance. Neither strobe is re-asserted for the current index once accepted.
  - When both are accepted (possibly in the same cycle), advance to i+1 and re-present both strobes the next cycle. Back-to-back throughput is 1 word/cycle when both ready signals stay high.
  - After index last_idx is fully accepted, set i=0 and go to READ.
- READ:
  - Issue app_en=1, app_cmd=001, app_addr = i*ADDR_STEP while issue index <= last_idx and outstanding < MAX_OUTSTANDING (registered count, no same-cycle bypass). Advance the issue index on app_en&app_rdy.
  - Outstanding count: +1 on read command accept, -1 on app_rd_data_valid; both in the same cycle leaves it unchanged.
  - Data returns in order. On each app_rd_data_valid:
    - Compare the full DATA_W against the expected value.
    - On mismatch, increment err_cnt (saturating at 0xFFFFFFFF). If it was the first mismatch, record the compare index.
    - Add data[31:0] to sum.
    - Advance the compare index.
  - When the compare index passes last_idx: go to DONE; r_done=1; r_pass = (err_cnt==0 including the current word); r_busy=0.
- app_en is never asserted outside WRITE/READ.
- w_start while busy is ignored.
- w_calib_done falling mid-run is not monitored.
- Reset mid-operation aborts immediately; strobes go to 0 asynchronously.
- last_idx=0 writes and reads exactly one word.

Decomposition:
- Package dram_tester_pkg:
  - state encodings;
  - CMD_READ/CMD_WRITE constants;
  - mode encodings;
  - LFSR tap constant.
- Sub-module m_pattern_gen:
  - holds the 32-bit generator;
  - load(seed, mode), step, index input;
  - replicated DATA_W output.
  - Instantiated twice: once for write, once for compare.

Test Plan:
- Mode 0, seed 0x1, last_idx 15, ideal memory model (rdy always 1, read latency 20 cycles) -> 16 writes at app_addr 0..0x78, 16 reads, r_pass=1, r_err_cnt=0, r_sum=16, r_state=4.
- Mode 2, seed 0: confirm the generator uses 1. Random app_rdy/app_wdf_rdy (50%, independent) -> each index's command and data are accepted exactly once, r_pass=1.
- Mode 1, seed 0x100, model corrupts word 5 and word 9 on readback -> r_err_cnt=2, r_first_err_idx=5, r_pass=0.
- MAX_OUTSTANDING=2, read latency 30 -> never more than 2 reads outstanding (assertion); no read data lost.
- w_calib_done held low 100 cycles -> app_en stays 0 and r_state=1; proceeds when calib rises. w_start pulse during WRITE is ignored.
- w_rst_n asserted mid-READ -> all outputs 0 the same cycle. A new w_start then yields a clean pass with r_sum recomputed.
